// File: rtl/karplus_pluck_ctrl.sv
// Karplus-Strong pluck excitation sequencer.
// On an accepted pluck it latches the note's tap select and divider, then
// drives a burst of LFSR noise into the voice's delay line through the
// noise / noise_en / noise_pulse handshake. When the burst is done it hands
// the voice back to its own sample clock. Every output is a flop.
module karplus_pluck_ctrl #(
  parameter int unsigned DEPTH = 700,
  parameter int unsigned HALF  = 2,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pluck,
  input  logic [9:0]  note_idx,
  input  logic [31:0] div_in,
  input  logic [1:0]  atten,
  output logic [15:0] noise,
  output logic        noise_en,
  output logic        noise_pulse,
  output logic [9:0]  sel_nota,
  output logic [31:0] div_freq_out,
  output logic        busy
);

  localparam int unsigned NW      = $clog2(DEPTH + 1);
  localparam int unsigned HW      = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [HW-1:0] HLAST = HW'(HALF - 1);
  localparam logic [9:0] TAP_MAX  = 10'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_FILL,
    S_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] pcnt_q, pcnt_d;
  logic [NW-1:0] n_q, n_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [15:0]   noise_q, noise_d;
  logic          en_q, en_d;
  logic          pulse_q, pulse_d;
  logic          busy_q, busy_d;
  logic [9:0]    sel_q, sel_d;
  logic [31:0]   div_q, div_d;

  logic [9:0]        tap;
  logic [15:0]       lfsr_nx;
  logic signed [15:0] lfsr_nx_s;
  logic [15:0]       noise_sh;
  logic [NW-1:0]     pcnt_inc;
  logic              adv;

  // LFSR successor, attenuated sample candidate and clamped tap select
  always_comb begin
    lfsr_nx   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    lfsr_nx_s = lfsr_nx;
    noise_sh  = 16'(lfsr_nx_s >>> atten);
    tap       = (note_idx > TAP_MAX) ? TAP_MAX : note_idx;
    pcnt_inc  = pcnt_q + NW'(1);
  end

  // Burst sequencing. Output flops are loaded with the values that belong to
  // the state being entered, so each output is registered yet still lines up
  // exactly with the state it describes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    n_d     = n_q;
    en_d    = en_q;
    pulse_d = pulse_q;
    busy_d  = busy_q;
    sel_d   = sel_q;
    div_d   = div_q;
    lfsr_d  = lfsr_q;
    noise_d = noise_q;
    adv     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pluck) begin
          sel_d   = tap;
          div_d   = div_in;
          n_d     = NW'({1'b0, tap}) + NW'(1);
          adv     = 1'b1;
          cnt_d   = '0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          pulse_d = 1'b0;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (cnt_q == HLAST) begin
          cnt_d   = '0;
          pcnt_d  = '0;
          pulse_d = 1'b1;
          state_d = S_FILL;
        end else begin
          cnt_d = cnt_q + HW'(1);
        end
      end
      S_FILL: begin
        if (cnt_q != HLAST) begin
          cnt_d = cnt_q + HW'(1);
        end else begin
          cnt_d = '0;
          if (pulse_q) begin
            // falling edge: count the pulse and stage the next sample so it
            // is settled well before the following rising edge
            pulse_d = 1'b0;
            pcnt_d  = pcnt_inc;
            adv     = (pcnt_inc < n_q);
          end else if (pcnt_q == n_q) begin
            en_d    = 1'b0;
            state_d = S_RELEASE;
          end else begin
            pulse_d = 1'b1;
          end
        end
      end
      S_RELEASE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (adv) begin
      lfsr_d  = lfsr_nx;
      noise_d = noise_sh;
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      n_q     <= '0;
      en_q    <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      sel_q   <= '0;
      div_q   <= '0;
      lfsr_q  <= SEED;
      noise_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      n_q     <= n_d;
      en_q    <= en_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      sel_q   <= sel_d;
      div_q   <= div_d;
      lfsr_q  <= lfsr_d;
      noise_q <= noise_d;
    end
  end

  assign noise        = noise_q;
  assign noise_en     = en_q;
  assign noise_pulse  = pulse_q;
  assign sel_nota     = sel_q;
  assign div_freq_out = div_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_karplus_pluck_ctrl.sv
// Bench for karplus_pluck_ctrl: a queue-based model expands each accepted
// pluck into its expected per-cycle output sequence; a negedge process
// compares the DUT against it and gathers burst statistics for directed checks.
module tb_karplus_pluck_ctrl;

  localparam int unsigned DEPTH = 700;
  localparam int unsigned HALF  = 2;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pluck = 1'b0;
  logic [9:0]  note_idx = '0;
  logic [31:0] div_in = '0;
  logic [1:0]  atten = '0;
  logic [15:0] noise;
  logic        noise_en;
  logic        noise_pulse;
  logic [9:0]  sel_nota;
  logic [31:0] div_freq_out;
  logic        busy;

  karplus_pluck_ctrl #(
    .DEPTH(DEPTH),
    .HALF (HALF),
    .SEED (SEED)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pluck       (pluck),
    .note_idx    (note_idx),
    .div_in      (div_in),
    .atten       (atten),
    .noise       (noise),
    .noise_en    (noise_en),
    .noise_pulse (noise_pulse),
    .sel_nota    (sel_nota),
    .div_freq_out(div_freq_out),
    .busy        (busy)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic en;
    logic pulse;
    logic busy;
    logic adv;
  } ent_t;

  ent_t        q[$];
  ent_t        cur = '0;
  logic [15:0] m_lfsr = SEED;
  logic [15:0] m_noise = '0;
  logic [9:0]  m_sel = '0;
  logic [31:0] m_div = '0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {1'b0, x[15:1]} ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic push(input logic en, input logic pl, input logic bz, input logic ad);
    ent_t e;
    e.en = en; e.pulse = pl; e.busy = bz; e.adv = ad;
    q.push_back(e);
  endtask

  // expected output sequence for one burst of n pulses
  task automatic build(input int unsigned n);
    for (int unsigned i = 0; i < HALF; i++) push(1'b1, 1'b0, 1'b1, i == 0);
    for (int unsigned k = 1; k <= n; k++) begin
      for (int unsigned i = 0; i < HALF; i++) push(1'b1, 1'b1, 1'b1, 1'b0);
      for (int unsigned i = 0; i < HALF; i++) push(1'b1, 1'b0, 1'b1, (i == 0) && (k < n));
    end
    push(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      q.delete();
      cur     = '0;
      m_lfsr  = SEED;
      m_noise = '0;
      m_sel   = '0;
      m_div   = '0;
    end else begin
      if (q.size() == 0 && !cur.busy && pluck) begin
        int unsigned t;
        t = (note_idx > DEPTH - 1) ? DEPTH - 1 : int'(note_idx);
        m_sel = 10'(t);
        m_div = div_in;
        build(t + 1);
      end
      if (q.size() != 0) cur = q.pop_front();
      else cur = '0;
      if (cur.adv) begin
        m_lfsr  = lfsr_step(m_lfsr);
        m_noise = 16'($signed(m_lfsr) >>> atten);
      end
    end
  end

  // ---------------- compare / monitor ----------------
  int          rises = 0, busy_cnt = 0, busy_len = 0, hi_cnt = 0, hi_min = 0, hi_max = 0;
  logic [15:0] rise_noise[$];
  logic        prev_en = 1'b0, prev_pulse = 1'b0, prev_busy = 1'b0;
  logic [15:0] prev_noise = '0;

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      prev_en = 1'b0; prev_pulse = 1'b0; prev_busy = 1'b0; hi_cnt = 0;
    end else begin
      chk("noise", noise, m_noise);
      chk("noise_en", noise_en, cur.en);
      chk("noise_pulse", noise_pulse, cur.pulse);
      chk("busy", busy, cur.busy);
      chk("sel_nota", sel_nota, m_sel);
      chk("div_freq_out", div_freq_out, m_div);
      chk("pulse_implies_en", noise_pulse & ~noise_en, 1'b0);
      if (noise_en != prev_en) chk("en_toggle_pulse_quiet", noise_pulse | prev_pulse, 1'b0);
      if (busy && !prev_busy) begin
        rises = 0; rise_noise.delete(); busy_cnt = 0; hi_min = 1000000; hi_max = 0;
      end
      if (busy) busy_cnt++;
      if (!busy && prev_busy) busy_len = busy_cnt;
      if (noise_pulse && !prev_pulse) begin
        rises++; rise_noise.push_back(noise); hi_cnt = 0;
      end
      if (noise_pulse) begin
        hi_cnt++;
        if (prev_pulse) chk("noise_stable_high", noise, prev_noise);
      end
      if (!noise_pulse && prev_pulse) begin
        if (hi_cnt < hi_min) hi_min = hi_cnt;
        if (hi_cnt > hi_max) hi_max = hi_cnt;
      end
      prev_en = noise_en; prev_pulse = noise_pulse; prev_busy = busy; prev_noise = noise;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [15:0] rn(input int i);
    if (rise_noise.size() > i) return rise_noise[i];
    return 16'hxxxx;
  endfunction

  task automatic do_pluck(input logic [9:0] idx, input logic [31:0] dv, input logic [1:0] at);
    @(negedge clk);
    chk("idle_before_pluck", busy, 1'b0);
    note_idx = idx; div_in = dv; atten = at; pluck = 1'b1;
    @(negedge clk);
    pluck = 1'b0;
    chk("en_after_accept", noise_en, 1'b1);
  endtask

  task automatic wait_done(input int maxc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("burst_end_timeout", busy, 1'b0);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_noise", noise, 16'h0);
    chk("rst_noise_en", noise_en, 1'b0);
    chk("rst_noise_pulse", noise_pulse, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sel", sel_nota, 10'd0);
    chk("rst_div", div_freq_out, 32'd0);
    reset_n = 1'b1;

    // basic burst, N=10
    do_pluck(10'd9, 32'd1134, 2'd0);
    wait_done(200);
    chk("t1_rises", rises, 10);
    chk("t1_busy_len", busy_len, 43);
    chk("t1_hi_min", hi_min, 2);
    chk("t1_hi_max", hi_max, 2);
    chk("t1_noise0", rn(0), 16'hE270);
    chk("t1_noise1", rn(1), 16'h7138);
    repeat (5) @(negedge clk);
    chk("t1_sel_hold", sel_nota, 10'd9);
    chk("t1_div_hold", div_freq_out, 32'd1134);

    // attenuated single pulse from a fresh seed
    do_reset();
    do_pluck(10'd0, 32'd77, 2'd2);
    wait_done(50);
    chk("t2_rises", rises, 1);
    chk("t2_busy_len", busy_len, 7);
    chk("t2_noise0", rn(0), 16'hF89C);

    // clamped tap index
    do_pluck(10'd1023, $urandom, 2'($urandom_range(0, 3)));
    chk("t3_sel_clamp", sel_nota, 10'd699);
    wait_done(4000);
    chk("t3_rises", rises, 700);
    chk("t3_busy_len", busy_len, 2803);

    // pluck during FILL is ignored
    do_pluck(10'd20, 32'd555, 2'($urandom_range(0, 3)));
    for (int i = 0; i < 200 && rises < 3; i++) @(negedge clk);
    chk("t4_reached_fill", rises >= 3, 1'b1);
    note_idx = 10'd5; div_in = 32'd99; pluck = 1'b1;
    @(negedge clk);
    pluck = 1'b0;
    wait_done(300);
    chk("t4_rises", rises, 21);
    chk("t4_busy_len", busy_len, 87);
    chk("t4_sel", sel_nota, 10'd20);
    chk("t4_div", div_freq_out, 32'd555);

    // pluck held high: re-arms on the first idle cycle
    @(negedge clk);
    note_idx = 10'd3; div_in = 32'd42; atten = 2'd1; pluck = 1'b1;
    wait_done(100);
    chk("t5_busy_len", busy_len, 19);
    @(negedge clk);
    chk("t5_restart", busy, 1'b1);
    pluck = 1'b0;
    wait_done(100);

    // asynchronous reset while noise_pulse is high
    do_pluck(10'd10, 32'd7, 2'd0);
    for (int i = 0; i < 200 && !(rises >= 2 && noise_pulse); i++) @(negedge clk);
    chk("t6_in_high_phase", noise_pulse, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_rst_noise", noise, 16'h0);
    chk("t6_rst_en", noise_en, 1'b0);
    chk("t6_rst_pulse", noise_pulse, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_sel", sel_nota, 10'd0);
    chk("t6_rst_div", div_freq_out, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    do_pluck(10'd4, 32'd8, 2'd0);
    wait_done(100);
    chk("t6_reseeded_noise0", rn(0), 16'hE270);

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      pluck    = ($urandom_range(0, 3) == 0);
      note_idx = 10'($urandom_range(0, 24));
      atten    = 2'($urandom_range(0, 3));
      div_in   = $urandom;
    end
    @(negedge clk);
    pluck = 1'b0;
    wait_done(500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/karplus_pluck_ctrl.md
Name: karplus_pluck_ctrl

Overview:
- Upstream excitation sequencer for the Karplus-Strong string voice. On a pluck request it latches the note's delay-tap select and sample-rate divider.
- It then drives the voice's `noise`, `noise_en` and `noise_pulse` inputs to shift a burst of LFSR white noise into the delay line.
- When the burst ends it hands the voice back to its divided sample clock.
- Its outputs connect directly to the voice's `noise`, `noise_en`, `noise_pulse`, `sel_nota` and `div_freq_in` inputs.

Parameters:
- DEPTH, 700, delay-line length; the largest legal tap index is DEPTH-1.
- HALF, 2, clk cycles per `noise_pulse` phase (high phase and low phase each last HALF cycles); minimum value 1.
- SEED, 16'hACE1, LFSR reset/seed value; must be non-zero.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- pluck  in  1  pluck request, level-sampled on each clk edge.
- note_idx  in  10  requested delay-tap index.
- div_in  in  32  sample-rate divider value for the note.
- atten  in  2  noise attenuation; arithmetic shift-right amount 0..3.
- noise  out  16  signed noise sample to the voice.
- noise_en  out  1  fill mode: the voice clock is `noise_pulse` and its output is muted.
- noise_pulse  out  1  fill-mode shift clock to the voice.
- sel_nota  out  10  latched tap index.
- div_freq_out  out  32  latched divider value.
- busy  out  1  burst in progress.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, lfsr=SEED;
  - noise, noise_en, noise_pulse, busy = 0;
  - sel_nota=0, div_freq_out=0;
  - phase and pulse counters = 0.
  - Reset asserted mid-burst aborts the burst immediately; all outputs take their reset values.
- All outputs are registered. No combinational path exists from any input to any output.
- LFSR: Galois, right-shift. next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000). It advances only when stated below.
- noise = $signed(lfsr_next) >>> atten. The register is updated at the same moment the LFSR advances. atten is sampled at each update.
- IDLE:
  - busy=0, noise_en=0, noise_pulse=0.
  - If pluck=1 at a clk edge, accept the request:
    - sel_nota <= (note_idx > DEPTH-1) ? DEPTH-1 : note_idx;
    - div_freq_out <= div_in;
    - N <= clamped index + 1 (the number of fill pulses);
    - advance the LFSR and load noise;
    - go to ARM.
- ARM:
  - noise_en=1, busy=1, noise_pulse=0, held for HALF cycles.
  - This is a guard period so the voice's clock mux switches while both of its clock candidates are quiet from this block's side.
  - Then go to FILL with pulse count = 0.
- FILL:
  - Each pulse is noise_pulse=1 for HALF cycles, then 0 for HALF cycles.
  - On the cycle noise_pulse falls, increment the pulse count.
  - If the count is still below N, also advance the LFSR and reload noise. noise is therefore stable across every rising edge of noise_pulse.
  - After the low phase of pulse N, go to RELEASE.
- RELEASE:
  - One cycle with noise_en=0, noise_pulse=0, busy=1. noise holds its last value.
  - Then go to IDLE (busy=0).
- noise_pulse is never high while noise_en is 0.
- noise_en changes only while noise_pulse is 0.
- pluck is ignored in ARM, FILL and RELEASE; there is no queuing. A pluck held high in IDLE starts a new burst on the first IDLE cycle.
- sel_nota and div_freq_out hold their values from acceptance until the next accepted pluck, including while the note plays after the burst.
- Total busy cycles = HALF + 2·HALF·N + 1.
- LFSR state persists across bursts; it is not reseeded.

Test Plan:
- Reset, then pluck (1 cycle) with note_idx=9, div_in=32'd1134, atten=0, HALF=2:
  - noise_en rises 1 cycle after acceptance;
  - exactly 10 noise_pulse rising edges occur, each high 2 cycles;
  - busy lasts 43 cycles;
  - sel_nota=9 and div_freq_out=1134 are held after the burst.
- Same run, noise values:
  - noise at the 1st pulse rising edge is 16'hE270;
  - at the 2nd rising edge it is 16'h7138;
  - the value is constant across every high phase.
- atten=2, fresh reset, pluck note_idx=0: noise at the single pulse = 16'hF89C (E270 >>> 2). N=1, so busy lasts 7 cycles.
- note_idx=1023 → sel_nota=699, and exactly 700 pulses are observed.
- A pluck pulse in the middle of FILL, and pluck held high through the burst:
  - the mid-FILL pluck is ignored, with no change to the pulse count or latched values;
  - with pluck held high, a second burst begins one cycle after busy falls.
- reset_n dropped during FILL with noise_pulse=1:
  - all outputs go to 0 asynchronously in the same cycle;
  - after release, a new pluck reproduces noise=16'hE270 for its first sample.
- Protocol checker across all tests:
  - noise_pulse=1 implies noise_en=1;
  - noise_en never toggles in the same cycle as a noise_pulse edge.
